// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared sound-effect channel constants and priority helper
//
// Imported by the scheduler and by the APU so both agree on the channel
// numbering and on the fixed dispatch priority.
//   NUM_SFX          number of sound-effect channels
//   SFX_SHEEP/SWORD/PLAYER  channel indices into evt/pending/locked
//   SFX_PRIO         channel indices, highest priority first
//   sfx_prio_select  one-hot of the highest-priority asserted request
package sfx_pkg;

    localparam int unsigned NUM_SFX    = 3;

    localparam int unsigned SFX_SHEEP  = 0;
    localparam int unsigned SFX_SWORD  = 1;
    localparam int unsigned SFX_PLAYER = 2;

    localparam int unsigned SFX_PRIO [NUM_SFX] = '{SFX_PLAYER, SFX_SWORD, SFX_SHEEP};

    function automatic logic [NUM_SFX-1:0] sfx_prio_select(input logic [NUM_SFX-1:0] req);
        logic [NUM_SFX-1:0] sel;
        logic               found;
        sel   = '0;
        found = 1'b0;
        for (int p = 0; p < NUM_SFX; p++) begin
            if (!found && req[SFX_PRIO[p]]) begin
                sel[SFX_PRIO[p]] = 1'b1;
                found            = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sfx_lockout_counter.sv
// rtl/sfx_lockout_counter.sv - per-channel frame lockout down-counter
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        channel dispatched this cycle; reload with LOCKOUT_FRAMES
//   tick        frame boundary; decrement if nonzero and not loading
//   nonzero     channel is currently locked out
module sfx_lockout_counter #(
    parameter int LOCKOUT_FRAMES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic nonzero
);

    localparam int CNT_W = $clog2(LOCKOUT_FRAMES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCKOUT_FRAMES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // A load on a tick cycle wins, so the freshly dispatched channel
        // keeps its full lockout instead of losing one frame immediately.
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/sfx_event_scheduler.sv
// rtl/sfx_event_scheduler.sv - frame-synchronous sound-effect event scheduler
//
// Rising-edge-detects the collision flags, latches them as pending requests
// and releases at most one per frame (priority player > sword > sheep) as a
// one-cycle evt pulse. Dispatched channels are locked out for LOCKOUT_FRAMES
// frame ticks; edges arriving while locked are discarded and counted.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                low: ignore edges and clear pending requests
//   *_dragon_col          raw collision levels
//   x, y                  current pixel position (origin marks frame start)
//   evt[2:0]              one-cycle dispatch pulses to the APU
//   pending[2:0]          latched, not-yet-dispatched requests
//   locked[2:0]           channel lockout active
//   drop_count[7:0]       saturating count of edges discarded by lockout
module sfx_event_scheduler
    import sfx_pkg::*;
#(
    parameter int LOCKOUT_FRAMES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                sheep_dragon_col,
    input  logic                sword_dragon_col,
    input  logic                player_dragon_col,
    input  logic [9:0]          x,
    input  logic [9:0]          y,
    output logic [NUM_SFX-1:0]  evt,
    output logic [NUM_SFX-1:0]  pending,
    output logic [NUM_SFX-1:0]  locked,
    output logic [7:0]          drop_count
);

    logic [NUM_SFX-1:0] col;
    logic [NUM_SFX-1:0] prev_q,    prev_d;
    logic [NUM_SFX-1:0] pending_q, pending_d;
    logic [NUM_SFX-1:0] evt_q,     evt_d;
    logic [7:0]         drop_q,    drop_d;
    logic               at_origin_q, at_origin_d;

    logic               origin;
    logic               tick;
    logic [NUM_SFX-1:0] rise;
    logic [NUM_SFX-1:0] dispatch;
    logic [NUM_SFX-1:0] latch;
    logic [NUM_SFX-1:0] drop_vec;
    logic [NUM_SFX-1:0] lock_nz;
    logic [1:0]         drop_inc;
    logic [8:0]         drop_sum;

    assign col[SFX_SHEEP]  = sheep_dragon_col;
    assign col[SFX_SWORD]  = sword_dragon_col;
    assign col[SFX_PLAYER] = player_dragon_col;

    always_comb begin
        origin      = (x == 10'd0) && (y == 10'd0);
        at_origin_d = origin;
        // Only the first cycle at the origin counts, so a held origin
        // still produces a single tick per frame.
        tick        = origin & ~at_origin_q;

        prev_d      = col;
        rise        = col & ~prev_q;

        dispatch    = tick ? sfx_prio_select(pending_q & {NUM_SFX{enable}}) : '0;
        evt_d       = dispatch;

        // An edge on the channel being dispatched this cycle counts as a
        // drop: its lockout is already committed. An edge while the bit is
        // simply pending is absorbed silently.
        drop_vec    = rise & {NUM_SFX{enable}} & (lock_nz | dispatch);
        latch       = rise & {NUM_SFX{enable}} & ~lock_nz & ~dispatch;

        if (enable) begin
            pending_d = (pending_q & ~dispatch) | latch;
        end else begin
            pending_d = '0;
        end

        drop_inc = '0;
        for (int i = 0; i < NUM_SFX; i++) begin
            drop_inc = drop_inc + {1'b0, drop_vec[i]};
        end
        drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '0;
            at_origin_q <= 1'b1;
            pending_q   <= '0;
            evt_q       <= '0;
            drop_q      <= '0;
        end else begin
            prev_q      <= prev_d;
            at_origin_q <= at_origin_d;
            pending_q   <= pending_d;
            evt_q       <= evt_d;
            drop_q      <= drop_d;
        end
    end

    for (genvar g = 0; g < NUM_SFX; g++) begin : g_lock
        sfx_lockout_counter #(
            .LOCKOUT_FRAMES (LOCKOUT_FRAMES)
        ) u_lock (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (dispatch[g]),
            .tick    (tick),
            .nonzero (lock_nz[g])
        );
    end

    assign evt        = evt_q;
    assign pending    = pending_q;
    assign locked     = lock_nz;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_sfx_event_scheduler.sv
// tb/tb_sfx_event_scheduler.sv - directed self-checking bench for sfx_event_scheduler
module tb_sfx_event_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       sheep = 1'b0;
    logic       sword = 1'b0;
    logic       player = 1'b0;
    logic [9:0] x = 10'd1;
    logic [9:0] y = 10'd1;
    logic [2:0] evt;
    logic [2:0] pending;
    logic [2:0] locked;
    logic [7:0] drop_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sfx_event_scheduler #(.LOCKOUT_FRAMES(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .sheep_dragon_col  (sheep),
        .sword_dragon_col  (sword),
        .player_dragon_col (player),
        .x                 (x),
        .y                 (y),
        .evt               (evt),
        .pending           (pending),
        .locked            (locked),
        .drop_count        (drop_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_on();
        x = 10'd0;
        y = 10'd0;
        step();
    endtask

    task automatic tick_off();
        x = 10'd5;
        y = 10'd3;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        sheep = 1'b0; sword = 1'b0; player = 1'b0;
        x = 10'd5; y = 10'd3;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        x = 10'd0; y = 10'd0;
        step();
        n_total++; if (evt !== 3'b000) $display("FAIL reset_evt: got %b want %b", evt, 3'b000); else n_pass++;
        n_total++; if (pending !== 3'b000) $display("FAIL reset_pending: got %b want %b", pending, 3'b000); else n_pass++;
        n_total++; if (locked !== 3'b000) $display("FAIL reset_locked: got %b want %b", locked, 3'b000); else n_pass++;
        n_total++; if (drop_count !== 8'd0) $display("FAIL reset_drop: got %0d want %0d", drop_count, 0); else n_pass++;
        // Origin held across release with a request latched: no spurious tick.
        rst_n = 1'b1;
        sheep = 1'b1;
        step();
        sheep = 1'b0;
        n_total++; if (pending !== 3'b001) $display("FAIL reset_first_pending: got %b want %b", pending, 3'b001); else n_pass++;
        step();
        n_total++; if (evt !== 3'b000) $display("FAIL reset_no_spurious_tick: got %b want %b", evt, 3'b000); else n_pass++;
        x = 10'd5; y = 10'd3;
        step();
    endtask

    task automatic test_basic();
        do_reset();
        x = 10'd100; y = 10'd50;
        sheep = 1'b1;
        step();
        n_total++; if (pending !== 3'b001) $display("FAIL basic_pending: got %b want %b", pending, 3'b001); else n_pass++;
        sheep = 1'b0;
        step(); step();
        tick_on();
        n_total++; if (evt !== 3'b001) $display("FAIL basic_evt: got %b want %b", evt, 3'b001); else n_pass++;
        n_total++; if (pending !== 3'b000) $display("FAIL basic_pending_clear: got %b want %b", pending, 3'b000); else n_pass++;
        n_total++; if (locked !== 3'b001) $display("FAIL basic_locked: got %b want %b", locked, 3'b001); else n_pass++;
        tick_off();
        n_total++; if (evt !== 3'b000) $display("FAIL basic_evt_one_cycle: got %b want %b", evt, 3'b000); else n_pass++;
    endtask

    task automatic test_priority();
        logic [2:0] exp_evt [3];
        logic [2:0] exp_pend [3];
        exp_evt  = '{3'b100, 3'b010, 3'b001};
        exp_pend = '{3'b011, 3'b001, 3'b000};
        do_reset();
        sheep = 1'b1; sword = 1'b1; player = 1'b1;
        step();
        sheep = 1'b0; sword = 1'b0; player = 1'b0;
        n_total++; if (pending !== 3'b111) $display("FAIL prio_pending_all: got %b want %b", pending, 3'b111); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick_on();
            n_total++; if (evt !== exp_evt[k]) $display("FAIL prio_evt_%0d: got %b want %b", k, evt, exp_evt[k]); else n_pass++;
            n_total++; if (pending !== exp_pend[k]) $display("FAIL prio_pending_%0d: got %b want %b", k, pending, exp_pend[k]); else n_pass++;
            tick_off();
        end
        n_total++; if (locked !== 3'b111) $display("FAIL prio_locked: got %b want %b", locked, 3'b111); else n_pass++;
    endtask

    task automatic test_lockout();
        logic [2:0] exp;
        do_reset();
        for (int f = 1; f <= 10; f++) begin
            player = 1'b0;
            step();
            player = 1'b1;
            step(); step();
            tick_on();
            exp = (f == 1 || f == 10) ? 3'b100 : 3'b000;
            n_total++; if (evt !== exp) $display("FAIL lockout_evt_frame%0d: got %b want %b", f, evt, exp); else n_pass++;
            tick_off();
        end
        n_total++; if (drop_count !== 8'd8) $display("FAIL lockout_drop_count: got %0d want %0d", drop_count, 8); else n_pass++;
        player = 1'b0;
    endtask

    task automatic test_held_origin();
        int evt_seen;
        do_reset();
        sheep = 1'b1; step(); sheep = 1'b0; step();
        tick_on(); tick_off();
        for (int k = 0; k < 6; k++) begin
            tick_on(); tick_off();
        end
        sword = 1'b1; step(); sword = 1'b0; step();
        n_total++; if (pending !== 3'b010) $display("FAIL held_pending: got %b want %b", pending, 3'b010); else n_pass++;
        evt_seen = 0;
        x = 10'd0; y = 10'd0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (evt[1]) evt_seen++;
        end
        x = 10'd5; y = 10'd3;
        step();
        if (evt[1]) evt_seen++;
        n_total++; if (evt_seen != 1) $display("FAIL held_evt_count: got %0d want %0d", evt_seen, 1); else n_pass++;
        n_total++; if (locked !== 3'b011) $display("FAIL held_single_decrement: got %b want %b", locked, 3'b011); else n_pass++;
        tick_on();
        n_total++; if (locked !== 3'b010) $display("FAIL held_next_tick_locked: got %b want %b", locked, 3'b010); else n_pass++;
        tick_off();
    endtask

    task automatic test_enable();
        logic [7:0] drops_before;
        do_reset();
        player = 1'b1; step(); player = 1'b0; step();
        tick_on(); tick_off();
        sheep = 1'b1; sword = 1'b1; step(); sheep = 1'b0; sword = 1'b0;
        n_total++; if (pending !== 3'b011) $display("FAIL en_pending_set: got %b want %b", pending, 3'b011); else n_pass++;
        drops_before = drop_count;
        enable = 1'b0;
        step();
        n_total++; if (pending !== 3'b000) $display("FAIL en_pending_clear: got %b want %b", pending, 3'b000); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            sheep = 1'b1; sword = 1'b1; player = 1'b1; step();
            sheep = 1'b0; sword = 1'b0; player = 1'b0; step();
        end
        tick_on();
        n_total++; if (evt !== 3'b000) $display("FAIL en_no_evt: got %b want %b", evt, 3'b000); else n_pass++;
        n_total++; if (drop_count !== drops_before) $display("FAIL en_drop_unchanged: got %0d want %0d", drop_count, drops_before); else n_pass++;
        tick_off();
        enable = 1'b1;
    endtask

    task automatic test_simultaneous();
        do_reset();
        sheep = 1'b1; step(); sheep = 1'b0; step();
        sheep = 1'b1; sword = 1'b1;
        tick_on();
        sheep = 1'b0; sword = 1'b0;
        n_total++; if (evt !== 3'b001) $display("FAIL simul_evt: got %b want %b", evt, 3'b001); else n_pass++;
        n_total++; if (pending !== 3'b010) $display("FAIL simul_pending: got %b want %b", pending, 3'b010); else n_pass++;
        n_total++; if (drop_count !== 8'd1) $display("FAIL simul_drop: got %0d want %0d", drop_count, 1); else n_pass++;
        tick_off();
    endtask

    task automatic test_async_reset();
        do_reset();
        sheep = 1'b1; step(); sheep = 1'b0; step();
        tick_on();
        n_total++; if (evt !== 3'b001) $display("FAIL areset_evt_pre: got %b want %b", evt, 3'b001); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (evt !== 3'b000) $display("FAIL areset_evt_killed: got %b want %b", evt, 3'b000); else n_pass++;
        n_total++; if (locked !== 3'b000) $display("FAIL areset_locked: got %b want %b", locked, 3'b000); else n_pass++;
        n_total++; if (pending !== 3'b000) $display("FAIL areset_pending: got %b want %b", pending, 3'b000); else n_pass++;
        x = 10'd5; y = 10'd3;
        step();
        rst_n = 1'b1;
        step();
        tick_on();
        n_total++; if (evt !== 3'b000) $display("FAIL areset_first_origin: got %b want %b", evt, 3'b000); else n_pass++;
        tick_off();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_lockout();
        test_held_origin();
        test_enable();
        test_simultaneous();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
